// File: rtl/lbp_pkg.sv
// Shared definitions for the parametrised LBP engine.
// Holds the engine state type, the bit position of every neighbour inside
// the 8-bit LBP code, and the single-neighbour compare function used by
// the window.
package lbp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SLIDE,
    ST_OUT,
    ST_DONE
  } lbp_state_t;

  // Bit position of each neighbour in the LBP code.
  localparam int LBP_B_TL = 0;
  localparam int LBP_B_T  = 1;
  localparam int LBP_B_TR = 2;
  localparam int LBP_B_L  = 3;
  localparam int LBP_B_R  = 4;
  localparam int LBP_B_BL = 5;
  localparam int LBP_B_B  = 6;
  localparam int LBP_B_BR = 7;

  // Widest pixel the compare function accepts; narrower pixels are
  // zero-extended by the caller.
  localparam int LBP_PIX_MAX = 16;

  // Neighbour test. The limit carries one extra bit so that C+thr never
  // wraps: a bright centre with a non-zero threshold yields 0, not a
  // spurious 1.
  function automatic logic lbp_cmp(input logic [LBP_PIX_MAX-1:0] n,
                                   input logic [LBP_PIX_MAX-1:0] c,
                                   input logic [LBP_PIX_MAX-1:0] thr,
                                   input logic                   mode);
    logic [LBP_PIX_MAX:0] lim;
    lim = {1'b0, c} + (mode ? {1'b0, thr} : {(LBP_PIX_MAX+1){1'b0}});
    return ({1'b0, n} >= lim);
  endfunction

endpackage

// File: rtl/lbp_window.sv
// 3x3 pixel window for the LBP engine.
// Ports:
//   clk, reset          clock, asynchronous active-high reset (clears window)
//   shift_en            move every column one place left (right column kept)
//   load_en             write load_data into [load_row][load_col]
//   load_row, load_col  target cell: row 0=top..2=bottom, col 0=left..2=right
//   load_data           pixel to write
//   mode, thr           compare mode and threshold
//   code                LBP code of the window as it will be after this edge
// The code is taken from the next-state view of the window so that the
// final pixel of a window can be captured and the code registered on the
// same clock edge.
module lbp_window
  import lbp_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic [1:0]       load_row,
  input  logic [1:0]       load_col,
  input  logic [PIX_W-1:0] load_data,
  input  logic             mode,
  input  logic [PIX_W-1:0] thr,
  output logic [7:0]       code
);

  localparam int LW = LBP_PIX_MAX;

  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic [LW-1:0]    cen;
  logic [LW-1:0]    thr_x;

  always_comb begin
    win_d = win_q;
    if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
    end
    if (load_en) begin
      win_d[load_row][load_col] = load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  assign cen   = LW'(win_d[1][1]);
  assign thr_x = LW'(thr);

  assign code[LBP_B_TL] = lbp_cmp(LW'(win_d[0][0]), cen, thr_x, mode);
  assign code[LBP_B_T]  = lbp_cmp(LW'(win_d[0][1]), cen, thr_x, mode);
  assign code[LBP_B_TR] = lbp_cmp(LW'(win_d[0][2]), cen, thr_x, mode);
  assign code[LBP_B_L]  = lbp_cmp(LW'(win_d[1][0]), cen, thr_x, mode);
  assign code[LBP_B_R]  = lbp_cmp(LW'(win_d[1][2]), cen, thr_x, mode);
  assign code[LBP_B_BL] = lbp_cmp(LW'(win_d[2][0]), cen, thr_x, mode);
  assign code[LBP_B_B]  = lbp_cmp(LW'(win_d[2][1]), cen, thr_x, mode);
  assign code[LBP_B_BR] = lbp_cmp(LW'(win_d[2][2]), cen, thr_x, mode);

endmodule

// File: rtl/lbp_engine_param.sv
// Local Binary Pattern engine for an IMG_W x IMG_H grayscale frame.
// Reads pixels through a 1-cycle-latency memory port, keeps a sliding 3x3
// window (9 reads on the first pixel of a row, 3 per pixel after that) and
// hands out one LBP code per interior pixel over a ready/valid port.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   gray_ready          start a frame (sampled only in IDLE)
//   gray_req, gray_addr pixel read request and address
//   gray_data           pixel data, one cycle after the request
//   mode, thr           compare mode and threshold, latched at frame start
//   lbp_addr, lbp_data  result address and code
//   lbp_valid, lbp_ready result handshake
//   finish              frame complete, held until reset
module lbp_engine_param
  import lbp_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  input  logic              mode,
  input  logic [PIX_W-1:0]  thr,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              lbp_valid,
  input  logic              lbp_ready,
  output logic              finish
);

  lbp_state_t        state, next_state;

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] top_base;   // (row-1)*IMG_W, accumulated per row
  logic              mode_q;
  logic [PIX_W-1:0]  thr_q;

  // Issue sequencer: walks rows inside a column, then columns.
  logic              iss_busy;
  logic [1:0]        iss_r;
  logic [1:0]        iss_c;
  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] iss_addr;

  // Capture tag, one cycle behind the issue that produced the data.
  logic              cap_vld_p0;
  logic [1:0]        cap_r_p0;
  logic [1:0]        cap_c_p0;
  logic              cap_last;

  logic              shift_en;
  logic [7:0]        win_code;

  assign cap_last = cap_vld_p0 && (cap_r_p0 == 2'd2) && (cap_c_p0 == 2'd2);
  assign shift_en = (state == ST_OUT) && lbp_ready && (next_state == ST_SLIDE);

  always_comb begin
    case (iss_r)
      2'd0:    row_off = '0;
      2'd1:    row_off = ADDR_W'(IMG_W);
      default: row_off = ADDR_W'(2 * IMG_W);
    endcase
  end

  assign iss_addr = top_base + row_off + col + ADDR_W'(iss_c) - ADDR_W'(1);

  lbp_window #(.PIX_W(PIX_W)) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .load_en  (cap_vld_p0),
    .load_row (cap_r_p0),
    .load_col (cap_c_p0),
    .load_data(gray_data),
    .mode     (mode_q),
    .thr      (thr_q),
    .code     (win_code)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (gray_ready) next_state = ST_FILL;
      end
      ST_FILL, ST_SLIDE: begin
        if (cap_last) next_state = ST_OUT;
      end
      ST_OUT: begin
        if (lbp_ready) begin
          if (col < ADDR_W'(IMG_W - 2))      next_state = ST_SLIDE;
          else if (row < ADDR_W'(IMG_H - 2)) next_state = ST_FILL;
          else                               next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gray_req  = iss_busy;
    gray_addr = iss_busy ? iss_addr : '0;
    lbp_valid = (state == ST_OUT);
    finish    = (state == ST_DONE);
  end

  // Issue stage -> capture stage (_p0), position counters, result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row        <= ADDR_W'(1);
      col        <= ADDR_W'(1);
      top_base   <= '0;
      mode_q     <= 1'b0;
      thr_q      <= '0;
      iss_busy   <= 1'b0;
      iss_r      <= 2'd0;
      iss_c      <= 2'd0;
      cap_vld_p0 <= 1'b0;
      cap_r_p0   <= 2'd0;
      cap_c_p0   <= 2'd0;
      lbp_addr   <= '0;
      lbp_data   <= '0;
    end else begin
      cap_vld_p0 <= iss_busy;
      cap_r_p0   <= iss_r;
      cap_c_p0   <= iss_c;

      if (iss_busy) begin
        if (iss_r == 2'd2) begin
          iss_r <= 2'd0;
          if (iss_c == 2'd2) iss_busy <= 1'b0;
          else               iss_c    <= iss_c + 2'd1;
        end else begin
          iss_r <= iss_r + 2'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (gray_ready) begin
            mode_q   <= mode;
            thr_q    <= thr;
            iss_busy <= 1'b1;
            iss_r    <= 2'd0;
            iss_c    <= 2'd0;
          end
        end
        ST_FILL, ST_SLIDE: begin
          if (cap_last) begin
            lbp_data <= win_code;
            lbp_addr <= top_base + ADDR_W'(IMG_W) + col;
          end
        end
        ST_OUT: begin
          if (next_state == ST_SLIDE) begin
            // Only the new right-hand column needs fetching.
            col      <= col + ADDR_W'(1);
            iss_busy <= 1'b1;
            iss_r    <= 2'd0;
            iss_c    <= 2'd2;
          end else if (next_state == ST_FILL) begin
            row      <= row + ADDR_W'(1);
            col      <= ADDR_W'(1);
            top_base <= top_base + ADDR_W'(IMG_W);
            iss_busy <= 1'b1;
            iss_r    <= 2'd0;
            iss_c    <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_engine_param.sv
// Directed bench for lbp_engine_param: a 4x4 instance and a 7x5 instance
// share clock, reset, mode/thr and lbp_ready; one is selected per frame.
module tb_lbp_engine_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       gray_ready_s, gray_ready_l;
  logic       mode;
  logic [7:0] thr;
  logic       lbp_ready;
  logic       sel;

  logic       gray_req_s, lbp_valid_s, finish_s;
  logic [3:0] gray_addr_s, lbp_addr_s;
  logic [7:0] gray_data_s, lbp_data_s;

  logic       gray_req_l, lbp_valid_l, finish_l;
  logic [5:0] gray_addr_l, lbp_addr_l;
  logic [7:0] gray_data_l, lbp_data_l;

  logic [7:0] img_s [16];
  logic [7:0] img_l [35];

  logic        req_m, valid_m, finish_m;
  logic [15:0] gaddr_m, laddr_m;
  logic [7:0]  ldata_m;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lbp_engine_param #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ADDR_W(4)) u_dut_s (
    .clk(clk), .reset(reset), .gray_ready(gray_ready_s), .gray_req(gray_req_s),
    .gray_addr(gray_addr_s), .gray_data(gray_data_s), .mode(mode), .thr(thr),
    .lbp_addr(lbp_addr_s), .lbp_data(lbp_data_s), .lbp_valid(lbp_valid_s),
    .lbp_ready(lbp_ready), .finish(finish_s)
  );

  lbp_engine_param #(.IMG_W(7), .IMG_H(5), .PIX_W(8), .ADDR_W(6)) u_dut_l (
    .clk(clk), .reset(reset), .gray_ready(gray_ready_l), .gray_req(gray_req_l),
    .gray_addr(gray_addr_l), .gray_data(gray_data_l), .mode(mode), .thr(thr),
    .lbp_addr(lbp_addr_l), .lbp_data(lbp_data_l), .lbp_valid(lbp_valid_l),
    .lbp_ready(lbp_ready), .finish(finish_l)
  );

  // Image memories with one cycle of read latency.
  always @(posedge clk) begin
    gray_data_s <= img_s[gray_addr_s];
    gray_data_l <= (gray_addr_l < 6'd35) ? img_l[gray_addr_l] : 8'h00;
  end

  assign req_m    = sel ? gray_req_l  : gray_req_s;
  assign valid_m  = sel ? lbp_valid_l : lbp_valid_s;
  assign finish_m = sel ? finish_l    : finish_s;
  assign gaddr_m  = sel ? {10'b0, gray_addr_l} : {12'b0, gray_addr_s};
  assign laddr_m  = sel ? {10'b0, lbp_addr_l}  : {12'b0, lbp_addr_s};
  assign ldata_m  = sel ? lbp_data_l  : lbp_data_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pat 0: pixel = address; pat 1: constant val.
  task automatic load_image(input int pat, input logic [7:0] val);
    for (int i = 0; i < 16; i++) img_s[i] = (pat == 0) ? 8'(i) : val;
    for (int i = 0; i < 35; i++) img_l[i] = (pat == 0) ? 8'(i) : val;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_req"},    {31'b0, req_m},    0);
    check({tag, "_gaddr"},  {16'b0, gaddr_m},  0);
    check({tag, "_valid"},  {31'b0, valid_m},  0);
    check({tag, "_laddr"},  {16'b0, laddr_m},  0);
    check({tag, "_ldata"},  {24'b0, ldata_m},  0);
    check({tag, "_finish"}, {31'b0, finish_m}, 0);
  endtask

  task automatic do_reset(input bit s);
    sel          = s;
    gray_ready_s = 1'b0;
    gray_ready_l = 1'b0;
    lbp_ready    = 1'b1;
    reset        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Runs a frame; every result is expected to carry exp code. stall holds
  // lbp_ready low for 5 cycles on the first result; stop_after > 0 returns
  // right after that many results have been seen.
  task automatic run_frame(input bit s, input int w, input int h, input bit md,
                           input logic [7:0] th, input logic [7:0] exp,
                           input bit stall, input int stop_after);
    int idx = 0;
    int cyc;
    int reqs;
    sel       = s;
    mode      = md;
    thr       = th;
    lbp_ready = !stall;
    if (s) gray_ready_l = 1'b1;
    else   gray_ready_s = 1'b1;
    for (int r = 1; r <= h - 2; r++) begin
      for (int c = 1; c <= w - 2; c++) begin
        cyc  = 0;
        reqs = 0;
        do begin
          @(negedge clk);
          gray_ready_s = 1'b0;
          gray_ready_l = 1'b0;
          cyc++;
          if (req_m) reqs++;
        end while (!valid_m && cyc < 40);
        check("valid", {31'b0, valid_m}, 1);
        if (!valid_m) return;
        check("latency", cyc, (c == 1) ? 11 : 5);
        check("reads", reqs, (c == 1) ? 9 : 3);
        check("addr", {16'b0, laddr_m}, r * w + c);
        check("code", {24'b0, ldata_m}, {24'b0, exp});
        check("finish_early", {31'b0, finish_m}, 0);
        if (idx == 0) begin
          // Mid-frame changes must not affect the rest of the frame.
          mode = ~md;
          thr  = th + 8'd5;
          if (stall) begin
            for (int k = 0; k < 5; k++) begin
              @(negedge clk);
              check("stall_valid", {31'b0, valid_m}, 1);
              check("stall_addr", {16'b0, laddr_m}, w + 1);
              check("stall_code", {24'b0, ldata_m}, {24'b0, exp});
              check("stall_req", {31'b0, req_m}, 0);
            end
            lbp_ready = 1'b1;
          end
        end
        idx++;
        if (stop_after > 0 && idx == stop_after) return;
      end
    end
    @(negedge clk);
    check("done_finish", {31'b0, finish_m}, 1);
    check("done_valid", {31'b0, valid_m}, 0);
    repeat (3) @(negedge clk);
    check("done_hold", {31'b0, finish_m}, 1);
    check("done_req", {31'b0, req_m}, 0);
    check("done_novalid", {31'b0, valid_m}, 0);
  endtask

  initial begin
    reset        = 1'b1;
    gray_ready_s = 1'b0;
    gray_ready_l = 1'b0;
    mode         = 1'b0;
    thr          = 8'd0;
    lbp_ready    = 1'b1;
    sel          = 1'b0;

    // 4x4, pixel = address: right, bottom row above centre.
    load_image(0, 8'd0);
    do_reset(1'b0);
    run_frame(1'b0, 4, 4, 1'b0, 8'd0, 8'hF0, 1'b0, 0);

    // Same image, thr=2 drops the right neighbour; stall on first result.
    do_reset(1'b0);
    run_frame(1'b0, 4, 4, 1'b1, 8'd2, 8'hE0, 1'b1, 0);

    // 7x5 constant images.
    load_image(1, 8'd100);
    do_reset(1'b1);
    run_frame(1'b1, 7, 5, 1'b0, 8'd0, 8'hFF, 1'b0, 0);

    load_image(1, 8'd255);
    do_reset(1'b1);
    run_frame(1'b1, 7, 5, 1'b1, 8'd1, 8'h00, 1'b0, 0);

    load_image(1, 8'd100);
    do_reset(1'b1);
    run_frame(1'b1, 7, 5, 1'b1, 8'd0, 8'hFF, 1'b0, 0);

    // 7x5 pixel = address, thr=7: only bottom and bottom-right reach C+7.
    load_image(0, 8'd0);
    do_reset(1'b1);
    run_frame(1'b1, 7, 5, 1'b1, 8'd7, 8'hC0, 1'b0, 0);

    // Abort during row 2, then a complete clean frame.
    do_reset(1'b1);
    run_frame(1'b1, 7, 5, 1'b0, 8'd0, 8'hF0, 1'b0, 5);
    repeat (3) @(negedge clk);
    check("abort_busy", {31'b0, req_m}, 1);
    #2 reset = 1'b1;
    #1 all_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_idle_req", {31'b0, req_m}, 0);
    check("abort_idle_valid", {31'b0, valid_m}, 0);
    run_frame(1'b1, 7, 5, 1'b0, 8'd0, 8'hF0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lbp_engine_param.md
Name: lbp_engine_param

Overview:
- Parametrised successor to the fixed 128x128 LBP engine.
- Computes the 8-bit Local Binary Pattern for every interior pixel of an IMG_W x IMG_H grayscale image held in host memory.
- Reuses the sliding window across columns: 3 reads per step instead of 9. Adds an output ready/valid handshake with backpressure and a selectable threshold mode.
- Sits between the gray-image memory port and the LBP result memory.

Parameters:
- IMG_W, 128, image width in pixels (>=3)
- IMG_H, 128, image height in pixels (>=3)
- PIX_W, 8, grayscale pixel width in bits
- ADDR_W, 14, address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- gray_ready  in  1  image available; starts a frame when sampled high in IDLE
- gray_req  out  1  read request, high on each address-issue cycle
- gray_addr  out  ADDR_W  read address = row*IMG_W+col
- gray_data  in  PIX_W  read data, valid exactly 1 cycle after the request cycle
- mode  in  1  0: neighbour>=centre; 1: neighbour>=centre+thr
- thr  in  PIX_W  threshold for mode 1
- lbp_addr  out  ADDR_W  result address = row*IMG_W+col
- lbp_data  out  8  LBP code
- lbp_valid  out  1  result valid
- lbp_ready  in  1  result accepted when high with lbp_valid
- finish  out  1  frame complete; sticky until reset

Behaviour:
- Reset: all outputs 0. FSM enters IDLE; row=1, col=1; window registers 0.
- FSM states: IDLE, FILL, SLIDE, OUT, DONE.
- IDLE -> FILL when gray_ready=1. mode and thr are latched on this transition; changes mid-frame are ignored. gray_ready is not sampled again until reset.
- FILL (first pixel of each row): 9 consecutive issue cycles, column-major from col-1 to col+1, top/mid/bottom within each column. Each datum is captured 1 cycle after its issue.
- SLIDE (col>1): window shifts left by one column, then 3 issue cycles for column col+1 (top, mid, bottom).
- OUT is entered the cycle after the last datum is captured. lbp_valid=1; lbp_addr and lbp_data are registered and held stable while lbp_ready=0. gray_req=0 during OUT.
- On the handshake (lbp_valid & lbp_ready):
  - col < IMG_W-2: col++, go to SLIDE.
  - else if row < IMG_H-2: row++, col=1, go to FILL.
  - else go to DONE.
- DONE: finish=1, lbp_valid=0, gray_req=0. Remains in DONE until reset.
- Latency: FILL handshake-to-valid is 11 cycles; SLIDE is 5 cycles. Zero-wait throughput is 1 result per 5 cycles.
- Bit map, centre C: b0=top-left, b1=top, b2=top-right, b3=left, b4=right, b5=bottom-left, b6=bottom, b7=bottom-right.
- Compare: bit = N >= C (mode 0) or N >= C+thr (mode 1).
- C+thr is evaluated in PIX_W+1 bits, with no wrap or saturation. Example: C=255, thr=1 gives all bits 0.
- Address generation uses a row-base accumulator (+IMG_W per row); no multiplier.
- Border pixels (row/col 0 or last) are never written.
- Total results per frame: (IMG_W-2)*(IMG_H-2).
- Reset mid-frame: immediate abort. All outputs 0 and state IDLE; a new frame requires gray_ready.

Decomposition:
- Package lbp_pkg holds:
  - state enum type;
  - LBP bit-position constants;
  - function lbp_cmp(N, C, thr, mode).
- Sub-module lbp_window holds the 3x3 PIX_W register window. It provides column-load and shift-left controls and a combinational 8-bit code output.

Test Plan:
- IMG_W=IMG_H=4, pixel value = addr, mode 0 -> 4 results, addrs 5,6,9,10, each 0xF0; finish high after the 4th handshake.
- Same image, mode 1, thr=2 -> each result 0xE0.
- Default 128x128 constant image 100, mode 0 -> 15876 results of 0xFF, first addr 129, last addr 16254. Per row 1: 9 reads for the first pixel, then 3 per pixel.
- Constant image 255, mode 1, thr=1 -> every result 0x00 (no overflow wrap). Constant 100 with thr=0 -> 0xFF.
- lbp_ready low for 5 cycles on the first result -> lbp_valid, lbp_addr=IMG_W+1 and lbp_data held stable; gray_req=0 throughout; the next result follows 5 cycles after the handshake.
- Assert reset during row 2 -> all outputs 0 the same cycle. Re-run with gray_ready -> complete, correct result sequence from addr IMG_W+1.
